// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D memory-port arbiter: FSM states, latched request record
// and the fixed instruction access size.
package mem_bus_arbiter_pkg;
   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_STRB_W = ARB_DATA_W / 8;

   localparam logic [2:0] MSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {IDLE, ADDR_I, ADDR_D, DATA_I, DATA_D} arb_state_t;

   // Field widths follow the package widths; the top defaults its parameters to them.
   typedef struct packed {
      logic [ARB_ADDR_W-1:0] addr;
      logic [2:0]            size;
      logic [ARB_STRB_W-1:0] strobe;
      logic [ARB_DATA_W-1:0] wdata;
   } arb_req_t;
endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Two-input grant logic for the memory arbiter. Fixed D-over-I priority by default;
// MEM_ARB_ROUND_ROBIN_EN alternates contended grants using a 1-bit last-grant register.
module arb_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic clk,
   input  logic reset,
   input  logic load,
`endif
   input  logic req_i,
   input  logic req_d,
   output logic grant_d,
   output logic grant_any
);
   assign grant_any = req_i | req_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_d;

   // On contention D wins only if I took the previous grant.
   assign grant_d = req_d & (~req_i | ~last_d);

   always_ff @(posedge clk) begin
      if (reset)     last_d <= 1'b0;
      else if (load) last_d <= grant_d;
   end
`else
   assign grant_d = req_d;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory handshake port between the instruction (I) and data (D) buses.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration in arb_pick.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_addr_ok,
   output logic                i_data_ok,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [2:0]          d_size,
   input  logic [DATA_W/8-1:0] d_strobe,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_addr_ok,
   output logic                d_data_ok,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [2:0]          m_size,
   output logic [DATA_W/8-1:0] m_strobe,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_addr_ok,
   input  logic                m_data_ok,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                m_owner_d
);
   arb_state_t state_q, state_d;
   arb_req_t   req_q, req_nxt;
   logic       owner_d_q;
   logic       load, done;
   logic       req_i_m, req_d_m, grant_d, grant_any;

   // In ADDR_x the owner's valid still belongs to the request being accepted,
   // so it must not count as a new request at a same-cycle completion.
   assign req_i_m = i_valid & (state_q != ADDR_I);
   assign req_d_m = d_valid & (state_q != ADDR_D);

   arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .clk       (clk),
      .reset     (reset),
      .load      (load),
`endif
      .req_i     (req_i_m),
      .req_d     (req_d_m),
      .grant_d   (grant_d),
      .grant_any (grant_any)
   );

   always_comb begin
      req_nxt = '0;
      if (grant_d) begin
         req_nxt.addr   = d_addr;
         req_nxt.size   = d_size;
         req_nxt.strobe = d_strobe;
         req_nxt.wdata  = d_wdata;
      end else begin
         req_nxt.addr   = i_addr;
         req_nxt.size   = MSIZE_WORD;
      end
   end

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      done      = 1'b0;
      m_valid   = 1'b0;
      i_addr_ok = 1'b0;
      i_data_ok = 1'b0;
      i_rdata   = '0;
      d_addr_ok = 1'b0;
      d_data_ok = 1'b0;
      d_rdata   = '0;
      case (state_q)
         IDLE: done = 1'b1;
         ADDR_I: begin
            m_valid   = 1'b1;
            i_addr_ok = m_addr_ok;
            if (m_addr_ok) begin
               if (m_data_ok) begin
                  i_data_ok = 1'b1;
                  i_rdata   = m_rdata;
                  done      = 1'b1;
               end else state_d = DATA_I;
            end
         end
         ADDR_D: begin
            m_valid   = 1'b1;
            d_addr_ok = m_addr_ok;
            if (m_addr_ok) begin
               if (m_data_ok) begin
                  d_data_ok = 1'b1;
                  d_rdata   = m_rdata;
                  done      = 1'b1;
               end else state_d = DATA_D;
            end
         end
         DATA_I: begin
            i_data_ok = m_data_ok;
            i_rdata   = m_rdata;
            done      = m_data_ok;
         end
         DATA_D: begin
            d_data_ok = m_data_ok;
            d_rdata   = m_rdata;
            done      = m_data_ok;
         end
         default: state_d = IDLE;
      endcase
      // Grant point: re-arbitrate immediately so back-to-back requests see no bubble.
      if (done) begin
         state_d = IDLE;
         if (grant_any) begin
            load    = 1'b1;
            state_d = grant_d ? ADDR_D : ADDR_I;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         req_q     <= '0;
         owner_d_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            req_q     <= req_nxt;
            owner_d_q <= grant_d;
         end
      end
   end

   assign m_addr    = req_q.addr;
   assign m_size    = req_q.size;
   assign m_strobe  = req_q.strobe;
   assign m_wdata   = req_q.wdata;
   assign m_owner_d = owner_d_q;

   always @(posedge clk) begin
      assert (reset || !m_data_ok || m_addr_ok || state_q == DATA_I || state_q == DATA_D)
         else $error("mem_bus_arbiter: m_data_ok without an accepted address");
   end
endmodule
